dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the core's data-memory port. Accepts one load/store request at a time over a valid/ready request channel, applies a configurable number of wait states, performs a byte/half/word access on internal word-organised storage, and returns load data plus an error flag over a valid/ready response channel. It lets the pipeline be validated against realistic multi-cycle memory instead of a zero-latency array.

## Interface
Parameters:
- DEPTH_LOG2, 10: log2 of storage depth in 32-bit words (default 1024 words = 4 KiB).
- LATENCY, 2: wait-state cycles between acceptance and commit; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 zero-extends, 0 sign-extends.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts response.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_error  out  1  misaligned, illegal size or out-of-range request.

## Operation
- States: IDLE, WAIT, RESP. Reset → IDLE.
- IDLE: req_ready=1. On req_valid&req_ready, latch write, addr, size, unsigned and wdata; load wait counter with LATENCY. Go to WAIT if LATENCY>0, else commit on this edge and go to RESP.
- WAIT: counter decrements each cycle. When it reaches 0, the access is committed on that edge and the state goes to RESP. Request inputs are ignored.
- RESP: rsp_valid=1; rsp_rdata and rsp_error are held stable until rsp_ready=1. On handshake, go to IDLE. Only one transaction is ever outstanding.
- Error check is done on the latched request at commit:
  - size 11;
  - half with addr[0]≠0;
  - word with addr[1:0]≠0;
  - addr[31:2] ≥ 2^DEPTH_LOG2.
- On error: no storage update, rsp_error=1, rsp_rdata=0.
- Word index is addr[DEPTH_LOG2+1:2].
- Store, byte: wdata[7:0] → lane addr[1:0].
- Store, half: wdata[15:0] → lanes {addr[1],0} and {addr[1],1}.
- Store, word: all four lanes. Other lanes are unchanged.
- Load: select the addressed lane(s), then sign-extend or zero-extend per req_unsigned. A word load ignores req_unsigned.
- Storage is not cleared by reset; contents persist across reset.
- Reset mid-transaction (WAIT or RESP): return to IDLE and drop the pending response. A store still in WAIT is not committed. A store already in RESP stays committed.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, counter=0.
- Requests presented while reset is high are not accepted.
- req_ready is decoded from state only, with no combinational path from req_valid.
- rsp_valid, rsp_rdata and rsp_error are registered outputs.
- Per-transaction cycle sequence, with request handshake in cycle 0:
  - cycles 1..LATENCY: WAIT;
  - cycle LATENCY+1: rsp_valid=1;
  - first possible next accept: cycle LATENCY+2, when rsp_ready=1 in cycle LATENCY+1.
- Maximum throughput: one transaction per LATENCY+2 cycles.
- Response backpressure: rsp_valid stays high indefinitely while rsp_ready=0, and req_ready stays 0 throughout.
- A store is visible to any load accepted after its response handshake.

## Test plan
- **Word store/load, LATENCY=2:** store 0xDEADBEEF at 0x10, then load word 0x10. Required: rsp_valid in cycle 3 after each accept, rsp_rdata=0xDEADBEEF, rsp_error=0.
- **Byte/half extension:** after the word store above:
  - signed byte load 0x13 → 0xFFFFFFDE;
  - unsigned byte load 0x13 → 0x000000DE;
  - signed half load 0x10 → 0xFFFFBEEF;
  - store byte 0x55 at 0x11, then word load 0x10 → 0xDEAD55EF.
- **Errors:** each of the following returns rsp_error=1 and rsp_rdata=0, and a following word load 0x20 returns the prior value unchanged:
  - half load at 0x21;
  - word store at 0x22;
  - size 11;
  - word load at 0x1000 with DEPTH_LOG2=10.
- **Backpressure:** hold rsp_ready=0 for 5 cycles. Required: rsp_valid and rsp_rdata stable throughout, req_ready=0 throughout, and a req_valid pulse during this window is not accepted.
- **LATENCY=0:** back-to-back loads with rsp_ready tied high. Required: rsp_valid in the cycle after each accept, and accepts every 2 cycles.
- **Reset mid-operation:** assert reset while a store of 0x12345678 to 0x40 is in WAIT. Required: outputs return to their reset values immediately, and a load of 0x40 after reset returns the pre-store value.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with wait states and byte/half/word access
// One request outstanding; wait states count down to a commit, then the response is held until taken.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam logic [3:0] LAT   = 4'(LATENCY);
  localparam int         WORDS = 1 << DEPTH_LOG2;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  write_q, unsigned_q;
  logic [31:0]           addr_q, wdata_q;
  logic [1:0]            size_q;
  logic                  rsp_valid_q, rsp_error_q;
  logic [31:0]           rsp_rdata_q;
  logic [31:0]           mem_q [WORDS];

  logic                  c_write, c_unsigned, c_err, commit, mem_we;
  logic [31:0]           c_addr, c_wdata, c_word, c_rdata, c_wword;
  logic [1:0]            c_size;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic [7:0]            c_byte;
  logic [15:0]           c_half;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

  // With zero wait states the commit lands on the accept edge, so the live request is used.
  assign c_write    = (state_q == S_IDLE) ? req_write    : write_q;
  assign c_addr     = (state_q == S_IDLE) ? req_addr     : addr_q;
  assign c_size     = (state_q == S_IDLE) ? req_size     : size_q;
  assign c_unsigned = (state_q == S_IDLE) ? req_unsigned : unsigned_q;
  assign c_wdata    = (state_q == S_IDLE) ? req_wdata    : wdata_q;

  assign commit = !reset && ((LATENCY == 0 && state_q == S_IDLE && req_valid) ||
                             (state_q == S_WAIT && cnt_q == 4'd1));

  assign c_err = (c_size == 2'b11) ||
                 (c_size == 2'b01 && c_addr[0]) ||
                 (c_size == 2'b10 && c_addr[1:0] != 2'b00) ||
                 ((c_addr >> (DEPTH_LOG2 + 2)) != 32'd0);

  assign c_idx  = c_addr[DEPTH_LOG2+1:2];
  assign c_word = mem_q[c_idx];
  assign c_byte = c_word[{c_addr[1:0], 3'b000} +: 8];
  assign c_half = c_word[{c_addr[1], 4'b0000} +: 16];
  assign mem_we = commit && c_write && !c_err;

  always_comb begin
    c_rdata = 32'd0;
    if (!c_err && !c_write) begin
      case (c_size)
        2'b00:   c_rdata = c_unsigned ? {24'd0, c_byte} : {{24{c_byte[7]}}, c_byte};
        2'b01:   c_rdata = c_unsigned ? {16'd0, c_half} : {{16{c_half[15]}}, c_half};
        default: c_rdata = c_word;
      endcase
    end
  end

  always_comb begin
    c_wword = c_word;
    case (c_size)
      2'b00:   c_wword[{c_addr[1:0], 3'b000} +: 8] = c_wdata[7:0];
      2'b01:   c_wword[{c_addr[1], 4'b0000} +: 16] = c_wdata[15:0];
      default: c_wword = c_wdata;
    endcase
  end

  // Storage deliberately has no reset so contents survive it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[c_idx] <= c_wword;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= 32'd0;
      size_q      <= 2'd0;
      unsigned_q  <= 1'b0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            addr_q     <= req_addr;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
            cnt_q      <= LAT;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: cnt_q <= cnt_q - 4'd1;
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (commit) begin
        state_q     <= S_RESP;
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= c_rdata;
        rsp_error_q <= c_err;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
// A behavioural memory model predicts every response; directed literals pin the model.
module tb_dmem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_error;

  logic        b_req_valid, b_req_ready, b_req_write, b_req_unsigned;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [1:0]  b_req_size;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_error;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error));

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr), .req_size(b_req_size),
    .req_unsigned(b_req_unsigned), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_error(b_rsp_error));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h required %08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
  endtask

  // Behavioural model: memory as a sparse word map, access rules as plain arithmetic.
  logic [31:0] mdl_mem [int];

  function automatic logic [31:0] mdl_read(input int idx);
    if (mdl_mem.exists(idx)) return mdl_mem[idx];
    return 32'd0;
  endfunction

  function automatic logic mdl_err(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0) || (a / 4 >= 1024);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    logic [31:0] v;
    int sh;
    sh = int'(a % 4) * 8;
    v = mdl_read(int'(a / 4)) >> sh;
    if (s == 2'd0) begin
      v = v & 32'hFF;
      if (!u && v >= 128) v = v | 32'hFFFFFF00;
    end else if (s == 2'd1) begin
      v = v & 32'hFFFF;
      if (!u && v >= 32768) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic void mdl_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    sh = int'(a % 4) * 8;
    mask = (s == 2'd0) ? 32'hFF : (s == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
    mask = mask << sh;
    mdl_mem[int'(a / 4)] = (mdl_read(int'(a / 4)) & ~mask) | ((d << sh) & mask);
  endfunction

  bit          busy = 0;
  int          due;
  logic        p_write, p_err;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic [1:0]  p_size;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_error", 32'(rsp_error), 32'd0);
      busy = 0;
    end else begin
      check("req_ready", 32'(req_ready), 32'(!busy));
      check("rsp_valid", 32'(rsp_valid), 32'(busy && cyc >= due));
      if (busy && cyc >= due) begin
        check("rsp_rdata", rsp_rdata, p_rdata);
        check("rsp_error", 32'(rsp_error), 32'(p_err));
        if (rsp_ready) begin
          if (p_write && !p_err) mdl_store(p_addr, p_size, p_wdata);
          busy = 0;
        end
      end else if (!busy && req_valid) begin
        p_write = req_write;
        p_addr  = req_addr;
        p_size  = req_size;
        p_wdata = req_wdata;
        p_err   = mdl_err(req_addr, req_size);
        p_rdata = (p_err || req_write) ? 32'd0 : mdl_load(req_addr, req_size, req_unsigned);
        due     = cyc + LAT + 1;
        busy    = 1;
      end
    end
  end

  task automatic wait_accept(input string nm);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!req_ready && g < 40);
    if (!req_ready) timeout(nm);
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [1:0] s, input logic u,
                      input logic [31:0] d, output logic [31:0] rd, output logic e);
    int t0, g;
    req_write = w; req_addr = a; req_size = s; req_unsigned = u; req_wdata = d; req_valid = 1'b1;
    wait_accept("accept");
    t0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!rsp_valid && g < 40);
    if (!rsp_valid) timeout("response");
    check("latency", 32'(cyc - t0), 32'(LAT + 1));
    rd = rsp_rdata;
    e  = rsp_error;
    @(posedge clk); #1;
  endtask

  task automatic expect_ok(input string nm, input logic w, input logic [31:0] a, input logic [1:0] s,
                           input logic u, input logic [31:0] d, input logic [31:0] exp);
    logic [31:0] rd;
    logic e;
    send(w, a, s, u, d, rd, e);
    check({nm, "_rdata"}, rd, exp);
    check({nm, "_error"}, 32'(e), 32'd0);
  endtask

  task automatic expect_err(input string nm, input logic w, input logic [31:0] a, input logic [1:0] s,
                            input logic [31:0] d);
    logic [31:0] rd;
    logic e;
    send(w, a, s, 1'b0, d, rd, e);
    check({nm, "_rdata"}, rd, 32'd0);
    check({nm, "_error"}, 32'(e), 32'd1);
    expect_ok({nm, "_after"}, 1'b0, 32'h20, 2'd2, 1'b0, 32'd0, 32'hCAFEF00D);
  endtask

  typedef struct {
    logic w; logic [31:0] a; logic [1:0] s; logic u; logic [31:0] d; logic [31:0] exp;
  } vec_t;
  vec_t bv [5];

  task automatic drive_b(input vec_t v);
    b_req_write = v.w; b_req_addr = v.a; b_req_size = v.s; b_req_unsigned = v.u; b_req_wdata = v.d;
  endtask

  initial begin
    int g;
    reset = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'd0;
    b_req_valid = 1'b0; b_rsp_ready = 1'b1;
    bv[0] = '{1'b1, 32'h100, 2'd2, 1'b0, 32'h80F2A5C3, 32'h00000000};
    bv[1] = '{1'b0, 32'h100, 2'd2, 1'b0, 32'h0,        32'h80F2A5C3};
    bv[2] = '{1'b0, 32'h103, 2'd0, 1'b0, 32'h0,        32'hFFFFFF80};
    bv[3] = '{1'b0, 32'h100, 2'd1, 1'b1, 32'h0,        32'h0000A5C3};
    bv[4] = '{1'b0, 32'h102, 2'd1, 1'b0, 32'h0,        32'hFFFF80F2};
    drive_b(bv[0]);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    expect_ok("st_word",  1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h00000000);
    expect_ok("ld_word",  1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF);
    expect_ok("ld_sbyte", 1'b0, 32'h13, 2'd0, 1'b0, 32'h0,        32'hFFFFFFDE);
    expect_ok("ld_ubyte", 1'b0, 32'h13, 2'd0, 1'b1, 32'h0,        32'h000000DE);
    expect_ok("ld_shalf", 1'b0, 32'h10, 2'd1, 1'b0, 32'h0,        32'hFFFFBEEF);
    expect_ok("st_byte",  1'b1, 32'h11, 2'd0, 1'b0, 32'h00000055, 32'h00000000);
    expect_ok("ld_merge", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        32'hDEAD55EF);

    expect_ok("st_w20", 1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0);
    expect_err("err_half",  1'b0, 32'h21,   2'd1, 32'h0);
    expect_err("err_word",  1'b1, 32'h22,   2'd2, 32'hFFFFFFFF);
    expect_err("err_size",  1'b1, 32'h20,   2'd3, 32'h0);
    expect_err("err_range", 1'b0, 32'h1000, 2'd2, 32'h0);

    // Backpressure: response held five cycles, a stray store pulse must be ignored.
    rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
    wait_accept("bp_accept");
    @(posedge clk); #1;
    req_valid = 1'b0;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!rsp_valid && g < 40);
    if (!rsp_valid) timeout("bp_response");
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, 32'hDEAD55EF);
      check("bp_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      if (i == 1) begin
        req_write = 1'b1; req_wdata = 32'd0; req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    expect_ok("bp_after", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hDEAD55EF);

    // Reset while a store sits in wait states: it must never land.
    expect_ok("st_w40", 1'b1, 32'h40, 2'd2, 1'b0, 32'h0BADF00D, 32'h0);
    req_write = 1'b1; req_addr = 32'h40; req_size = 2'd2; req_wdata = 32'h12345678; req_valid = 1'b1;
    wait_accept("rst_accept");
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rstnow_req_ready", 32'(req_ready), 32'd1);
    check("rstnow_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstnow_rsp_rdata", rsp_rdata, 32'd0);
    check("rstnow_rsp_error", 32'(rsp_error), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    expect_ok("rst_ld40", 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 32'h0BADF00D);

    // Zero wait states, response always accepted: accept, respond, accept again.
    drive_b(bv[0]);
    b_req_valid = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!b_req_ready && g < 20);
    if (!b_req_ready) timeout("l0_first_accept");
    for (int i = 0; i < 5; i++) begin
      check("l0_idle_valid", 32'(b_rsp_valid), 32'd0);
      @(posedge clk); #1;
      if (i < 4) drive_b(bv[i + 1]);
      else b_req_valid = 1'b0;
      @(negedge clk);
      check("l0_valid", 32'(b_rsp_valid), 32'd1);
      check("l0_rdata", b_rsp_rdata, bv[i].exp);
      check("l0_error", 32'(b_rsp_error), 32'd0);
      check("l0_busy", 32'(b_req_ready), 32'd0);
      @(negedge clk);
      check("l0_ready", 32'(b_req_ready), 32'd1);
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
